dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, 32, data/address width in bits.
REQ-002 The block SHALL have parameter STARVE_LIMIT, 4, consecutive denied ext cycles before ext gets priority (legal range 1..15).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  MEM-stage load or store present this cycle.
REQ-006 cpu_we  input  1  1=store, 0=load.
REQ-007 cpu_addr  input  WIDTH  byte address from ALU.
REQ-008 cpu_wdata  input  WIDTH  store data (rs2).
REQ-009 cpu_funct3  input  3  load/store size/sign code.
REQ-010 cpu_stall  output  1  CPU request not granted this cycle; pipeline holds EX/MEM.
REQ-011 cpu_rdata  output  WIDTH  load data returned to the CPU.
REQ-012 cpu_rvalid  output  1  cpu_rdata valid this cycle.
REQ-013 ext_req  input  1  external loader/debug request; held stable until granted.
REQ-014 ext_we  input  1  1=word write, 0=word read.
REQ-015 ext_addr, ext_wdata  input  WIDTH each  external address and write data.
REQ-016 ext_gnt  output  1  external request accepted this cycle.
REQ-017 ext_rdata  output  WIDTH  read data to external port.
REQ-018 ext_rvalid  output  1  ext_rdata valid this cycle.
REQ-019 mem_addr, mem_wdata  output  WIDTH each  to data memory.
REQ-020 mem_wr_en, mem_rd_en  output  1 each  memory write/read strobe.
REQ-021 mem_funct3  output  3  access size to memory.
REQ-022 mem_rdata  input  WIDTH  memory read data, valid one cycle after mem_rd_en.

Function
REQ-023 Grant SHALL be decided combinationally each cycle; at most one requester granted.
REQ-024 State CPU_PRIO: cpu_req wins; ext granted only if cpu_req=0.
REQ-025 State EXT_PRIO: ext_req wins; CPU granted only if ext_req=0.
REQ-026 starv_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle ext_req=1 and ext_gnt=0; clear to 0 on ext_gnt.
REQ-027 CPU_PRIO -> EXT_PRIO when starv_cnt reaches STARVE_LIMIT; EXT_PRIO -> CPU_PRIO on the cycle after ext_gnt.
REQ-028 cpu_stall = cpu_req & ~cpu_granted; ext_gnt = ext_req & ext_granted.
REQ-029 Granted request drives mem_addr/mem_wdata; mem_wr_en=we, mem_rd_en=~we; no grant -> strobes 0, addr/wdata 0.
REQ-030 mem_funct3 = cpu_funct3 for CPU grant, 3'b010 (word) for ext grant.
REQ-031 Read latency exactly 1: a registered owner tag (NONE/CPU/EXT) set on a read grant routes mem_rdata to the owner's rdata and pulses its rvalid next cycle.
REQ-032 Non-owner rdata SHALL be 0; rvalid SHALL never assert for writes.
REQ-033 Back-to-back reads (CPU then ext, or vice versa) SHALL each return in order with one-cycle latency, no bubbles.

Reset
REQ-034 On reset: state=CPU_PRIO, starv_cnt=0, owner tag=NONE; next cycle cpu_rvalid=0, ext_rvalid=0, cpu_rdata=0, ext_rdata=0.
REQ-035 A read granted in the reset cycle or the cycle before SHALL NOT produce rvalid.
REQ-036 While reset=1 no grant: cpu_stall=cpu_req, ext_gnt=0, mem strobes 0.

Structure
REQ-037 Package dmem_arb_pkg SHALL hold arb_state_e {CPU_PRIO, EXT_PRIO}, owner_e {OWN_NONE, OWN_CPU, OWN_EXT}, and FUNCT3_WORD=3'b010.
REQ-038 Starvation counter SHALL be sub-module arb_starve_cnt (inc, clr, limit, hit outputs).

Verification
REQ-039 CPU load addr 0x10, ext idle -> mem_rd_en=1 same cycle, cpu_rvalid=1 next cycle with cpu_rdata=mem_rdata, cpu_stall=0.
REQ-040 ext write 0x20=0xDEADBEEF, cpu idle -> ext_gnt=1, mem_wr_en=1, mem_funct3=3'b010, no rvalid.
REQ-041 cpu_req and ext_req held high continuously, STARVE_LIMIT=4 -> ext_gnt on 5th cycle only, cpu_stall=1 that cycle, CPU wins cycles 1-4 and 6.
REQ-042 CPU read cycle N, ext read cycle N+1 -> cpu_rvalid at N+1, ext_rvalid at N+2, data not swapped.
REQ-043 CPU read granted, reset asserted next cycle -> cpu_rvalid stays 0, state CPU_PRIO, starv_cnt 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Priority states, read-owner tags and the word access code.
package dmem_arb_pkg;

    typedef enum logic {
        CPU_PRIO,
        EXT_PRIO
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_EXT
    } owner_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of cycles the external port waited.
// hit flags that the count is at the limit after this cycle.
module arb_starve_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic       hit
);

    logic [3:0] count;
    logic [3:0] count_next;

    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (inc && (count < limit))
            count_next = count + 4'd1;
    end

    // Looking at the next value lets priority flip in time for the
    // very next cycle instead of one cycle late.
    assign hit = (count_next == limit);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data memory between the MEM stage and an external port.
// Starvation-aware priority; one-cycle read return routed by owner tag.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic [2:0]       cpu_funct3,
    output logic             cpu_stall,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_rvalid,
    input  logic             ext_req,
    input  logic             ext_we,
    input  logic [WIDTH-1:0] ext_addr,
    input  logic [WIDTH-1:0] ext_wdata,
    output logic             ext_gnt,
    output logic [WIDTH-1:0] ext_rdata,
    output logic             ext_rvalid,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_wr_en,
    output logic             mem_rd_en,
    output logic [2:0]       mem_funct3,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state, state_next;
    owner_e     owner, owner_next;
    logic       cpu_granted;
    logic       ext_granted;
    logic       starve_hit;

    arb_starve_cnt u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (ext_req & ~ext_gnt),
        .clr   (ext_gnt),
        .limit (LIMIT),
        .hit   (starve_hit)
    );

    always_comb begin
        cpu_granted = 1'b0;
        ext_granted = 1'b0;
        if (!reset) begin
            if (state == EXT_PRIO) begin
                ext_granted = ext_req;
                cpu_granted = cpu_req & ~ext_req;
            end else begin
                cpu_granted = cpu_req;
                ext_granted = ext_req & ~cpu_req;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_granted;
    assign ext_gnt   = ext_req & ext_granted;

    always_comb begin
        state_next = state;
        unique case (state)
            CPU_PRIO: if (starve_hit) state_next = EXT_PRIO;
            EXT_PRIO: if (ext_gnt)    state_next = CPU_PRIO;
            default:                  state_next = CPU_PRIO;
        endcase
    end

    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_funct3 = '0;
        owner_next = OWN_NONE;
        unique case (1'b1)
            cpu_granted: begin
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
                mem_wr_en  = cpu_we;
                mem_rd_en  = ~cpu_we;
                mem_funct3 = cpu_funct3;
                owner_next = cpu_we ? OWN_NONE : OWN_CPU;
            end
            ext_granted: begin
                mem_addr   = ext_addr;
                mem_wdata  = ext_wdata;
                mem_wr_en  = ext_we;
                mem_rd_en  = ~ext_we;
                mem_funct3 = FUNCT3_WORD;
                owner_next = ext_we ? OWN_NONE : OWN_EXT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CPU_PRIO;
            owner <= OWN_NONE;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Gating with reset drops a read granted just before reset.
    assign cpu_rvalid = ~reset & (owner == OWN_CPU);
    assign ext_rvalid = ~reset & (owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter.
// Reference model tracks priority and waiting time in plain integers.
module tb_dmem_arbiter;

    localparam int W     = 32;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [W-1:0] cpu_addr = '0;
    logic [W-1:0] cpu_wdata = '0;
    logic [2:0]   cpu_funct3 = '0;
    logic         cpu_stall;
    logic [W-1:0] cpu_rdata;
    logic         cpu_rvalid;
    logic         ext_req = 1'b0;
    logic         ext_we = 1'b0;
    logic [W-1:0] ext_addr = '0;
    logic [W-1:0] ext_wdata = '0;
    logic         ext_gnt;
    logic [W-1:0] ext_rdata;
    logic         ext_rvalid;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_wr_en;
    logic         mem_rd_en;
    logic [2:0]   mem_funct3;
    logic [W-1:0] mem_rdata = '0;

    dmem_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_funct3 (cpu_funct3),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rdata  (ext_rdata),
        .ext_rvalid (ext_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: contents are a fixed hash of the address, junk when idle.
    always @(posedge clk)
        mem_rdata <= mem_rd_en ? mem_val(mem_addr) : $urandom();

    typedef struct {
        bit           is_ext;
        logic [W-1:0] data;
        int           due;
    } rsp_t;

    rsp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   active = 1'b0;

    bit   prio_ext = 1'b0;
    int   starve = 0;
    int   last_win = 0;

    logic         e_stall, e_gnt, e_wr, e_rd;
    logic [2:0]   e_f3;
    logic [W-1:0] e_addr, e_wdata;

    task automatic drive(
        input bit rst, input bit creq, input bit cwe,
        input logic [W-1:0] ca, input logic [W-1:0] cd,
        input logic [2:0] cf, input bit ereq, input bit ewe,
        input logic [W-1:0] ea, input logic [W-1:0] ed);
        int win;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        cpu_req = creq; cpu_we = cwe; cpu_addr = ca;
        cpu_wdata = cd; cpu_funct3 = cf;
        ext_req = ereq; ext_we = ewe; ext_addr = ea;
        ext_wdata = ed;
        if (rst) q.delete();
        if (rst) win = 0;
        else if (creq && ereq) win = prio_ext ? 2 : 1;
        else if (creq) win = 1;
        else if (ereq) win = 2;
        else win = 0;
        last_win = win;
        e_stall = creq && (win != 1);
        e_gnt = (win == 2);
        e_wr = 0; e_rd = 0; e_f3 = 0; e_addr = 0; e_wdata = 0;
        if (win == 1) begin
            e_wr = cwe; e_rd = !cwe; e_f3 = cf;
            e_addr = ca; e_wdata = cd;
            if (!cwe) q.push_back('{0, mem_val(ca), cyc + 1});
        end else if (win == 2) begin
            e_wr = ewe; e_rd = !ewe; e_f3 = 3'b010;
            e_addr = ea; e_wdata = ed;
            if (!ewe) q.push_back('{1, mem_val(ea), cyc + 1});
        end
        if (rst) begin
            prio_ext = 0; starve = 0;
        end else if (win == 2) begin
            prio_ext = 0; starve = 0;
        end else if (ereq) begin
            if (starve < LIMIT) starve++;
            if (starve == LIMIT) prio_ext = 1;
        end
        active = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            chk("stall", W'(cpu_stall), W'(e_stall));
            chk("ext_gnt", W'(ext_gnt), W'(e_gnt));
            chk("strobes", W'({mem_wr_en, mem_rd_en, mem_funct3}),
                W'({e_wr, e_rd, e_f3}));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            if (cpu_rvalid || ext_rvalid) begin
                if (q.size() == 0) begin
                    chk("spurious_rvalid",
                        W'({cpu_rvalid, ext_rvalid}), '0);
                end else begin
                    rsp_t r;
                    r = q.pop_front();
                    chk("rsp_due", W'(cyc), W'(r.due));
                    chk("rsp_owner", W'({cpu_rvalid, ext_rvalid}),
                        r.is_ext ? W'(1) : W'(2));
                    chk("rsp_data", r.is_ext ? ext_rdata : cpu_rdata,
                        r.data);
                    chk("rsp_other", r.is_ext ? cpu_rdata : ext_rdata,
                        '0);
                end
            end else begin
                if (q.size() != 0 && q[0].due <= cyc) begin
                    chk("missing_rvalid", '0, W'(q[0].due));
                    void'(q.pop_front());
                end
                chk("idle_rdata", cpu_rdata | ext_rdata, '0);
            end
        end
    end

    logic [W-1:0] z = '0;

    initial begin
        bit           creq, cwe, ereq, ewe, rst;
        logic [W-1:0] ea, ed;
        drive(1, 1, 0, 32'h4, z, 3'b010, 1, 0, 32'h8, z);
        drive(1, 0, 0, z, z, 0, 0, 0, z, z);
        drive(0, 0, 0, z, z, 0, 0, 0, z, z);
        // CPU load, then external word write.
        drive(0, 1, 0, 32'h10, z, 3'b010, 0, 0, z, z);
        drive(0, 0, 0, z, z, 0, 1, 1, 32'h20, 32'hDEAD_BEEF);
        drive(0, 0, 0, z, z, 0, 0, 0, z, z);
        // Both held: ext must win the fifth cycle only.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 32'h100 + 32'(i), 32'(i), 3'b001,
                  !(i > 4), 0, 32'h200, z);
            if (i == 4 && last_win != 2) begin
                errors++;
                $display("FAIL starve_grant cyc=%0d got=%0d want=2",
                         cyc, last_win);
            end
            checks += (i == 4) ? 1 : 0;
        end
        // Back-to-back reads from both sides.
        drive(0, 1, 0, 32'h30, z, 3'b010, 0, 0, z, z);
        drive(0, 0, 0, z, z, 0, 1, 0, 32'h34, z);
        drive(0, 0, 0, z, z, 0, 0, 0, z, z);
        // Read followed immediately by reset.
        drive(0, 1, 0, 32'h44, z, 3'b100, 0, 0, z, z);
        drive(1, 0, 0, z, z, 0, 0, 0, z, z);
        drive(0, 0, 0, z, z, 0, 0, 0, z, z);
        ereq = 0; ewe = 0; ea = 0; ed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!ereq || last_win == 2) begin
                ereq = ($urandom_range(0, 2) != 0);
                ewe = $urandom_range(0, 1) == 1;
                ea = $urandom(); ed = $urandom();
            end
            rst = ($urandom_range(0, 99) == 0);
            creq = ($urandom_range(0, 3) != 0);
            cwe = $urandom_range(0, 1) == 1;
            drive(rst, creq, cwe, $urandom(), $urandom(),
                  3'($urandom()), ereq, ewe, ea, ed);
            if (rst) ereq = 0;
        end
        drive(0, 0, 0, z, z, 0, 0, 0, z, z);
        drive(0, 0, 0, z, z, 0, 0, 0, z, z);
        @(negedge clk);
        #1;
        chk("queue_empty", W'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
